master_output_control: RTL and testbench

MASTER_OUTPUT_CONTROL -- requirements
Module: master_output_control

---
 rtl/master_output_control.sv | 119 +++++++++++
 tb/tb_master_output_control.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/master_output_control.sv
// Drains accumulator rows of one systolic-array submatrix into output memory, optionally applying ReLU and clearing it.
// Reads rows over N cycles; column writes trail the reads by one cycle, then an optional clear cycle and a done pulse.
module master_output_control #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8,
    localparam int SMR = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS),
    localparam int SMC = $clog2(MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int RW  = $clog2(SYS_ARR_ROWS),
    localparam int CW  = $clog2(SYS_ARR_COLS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               done,
    input  logic [SMR-1:0]                     submat_row_in,
    input  logic [SMC-1:0]                     submat_col_in,
    output logic [SMR-1:0]                     submat_row_out,
    output logic [SMC-1:0]                     submat_col_out,
    input  logic [RW-1:0]                      num_rows_read,
    input  logic [CW-1:0]                      num_cols_read,
    output logic [RW-1:0]                      row_num,
    output logic                               accum_reset,
    input  logic                               activate,
    output logic                               relu_en,
    input  logic                               clear_after,
    input  logic [ADDR_WIDTH-1:0]              wr_base_addr,
    output logic [SYS_ARR_COLS-1:0]            wr_en,
    output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, CLEAR, DONE} state_t;

    state_t                  state_q, state_d;
    logic [RW-1:0]           nrows_q;
    logic [CW-1:0]           ncols_q;
    logic                    act_q;
    logic                    clr_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [SYS_ARR_COLS-1:0] col_mask;
    logic [ADDR_WIDTH-1:0]   addr_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (row_num == nrows_q) state_d = DRAIN;
            DRAIN:   state_d = clr_q ? CLEAR : DONE;
            CLEAR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The row read this cycle lands in memory next cycle, one address per row.
    always_comb begin
        col_mask = '0;
        for (int c = 0; c < SYS_ARR_COLS; c++) begin
            col_mask[c] = (c <= int'(ncols_q));
        end
        addr_d = base_q + ADDR_WIDTH'(row_num);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            nrows_q        <= '0;
            ncols_q        <= '0;
            act_q          <= 1'b0;
            clr_q          <= 1'b0;
            base_q         <= '0;
            submat_row_out <= '0;
            submat_col_out <= '0;
            row_num        <= '0;
            wr_en          <= '0;
            wr_addr        <= '0;
            accum_reset    <= 1'b0;
            done           <= 1'b0;
            relu_en        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    row_num <= '0;
                    if (start) begin
                        nrows_q        <= num_rows_read;
                        ncols_q        <= num_cols_read;
                        act_q          <= activate;
                        clr_q          <= clear_after;
                        base_q         <= wr_base_addr;
                        submat_row_out <= submat_row_in;
                        submat_col_out <= submat_col_in;
                    end
                end
                READ:    row_num <= (row_num == nrows_q) ? '0 : row_num + RW'(1);
                default: row_num <= '0;
            endcase

            if (state_q == READ) begin
                wr_en   <= col_mask;
                wr_addr <= {SYS_ARR_COLS{addr_d}};
            end else begin
                wr_en   <= '0;
            end

            accum_reset <= (state_d == CLEAR);
            done        <= (state_d == DONE);

            // On the start edge the latched copy is not yet valid, so take activate directly.
            case (state_d)
                READ, DRAIN, CLEAR: relu_en <= (state_q == IDLE) ? activate : act_q;
                default:            relu_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_master_output_control.sv
// Directed and randomized transfers checked cycle-by-cycle against an arithmetic timeline model.
module tb_master_output_control;

    localparam int SMR = 3, SMC = 3, RW = 4, CW = 4, AW = 8, COLS = 16;

    logic               clk = 1'b0;
    logic               reset, start, done, accum_reset, activate, relu_en, clear_after;
    logic [SMR-1:0]     submat_row_in, submat_row_out;
    logic [SMC-1:0]     submat_col_in, submat_col_out;
    logic [RW-1:0]      num_rows_read, row_num;
    logic [CW-1:0]      num_cols_read;
    logic [AW-1:0]      wr_base_addr;
    logic [COLS-1:0]    wr_en;
    logic [COLS*AW-1:0] wr_addr;

    int checks = 0;
    int fails  = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [2:0]    prev_sr = '0, prev_sc = '0;

    master_output_control dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .submat_row_in(submat_row_in), .submat_col_in(submat_col_in),
        .submat_row_out(submat_row_out), .submat_col_out(submat_col_out),
        .num_rows_read(num_rows_read), .num_cols_read(num_cols_read),
        .row_num(row_num), .accum_reset(accum_reset), .activate(activate),
        .relu_en(relu_en), .clear_after(clear_after), .wr_base_addr(wr_base_addr),
        .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        submat_row_in = SMR'($urandom);
        submat_col_in = SMC'($urandom);
        num_rows_read = RW'($urandom);
        num_cols_read = CW'($urandom);
        activate      = 1'($urandom);
        clear_after   = 1'($urandom);
        wr_base_addr  = AW'($urandom);
    endtask

    // Runs one transfer; rst_cyc>0 aborts it with reset low in that cycle,
    // restart_cyc>0 re-pulses start in that cycle, restart_done re-pulses it in the done cycle.
    task automatic xfer(input int sr, input int sc, input int nr, input int nc, input int act,
                        input int clr, input int base, input int rst_cyc, input int restart_cyc,
                        input bit restart_done);
        int n, k, dn, last;
        logic [COLS-1:0] mask;
        logic [AW-1:0]   a;
        bit aborted;
        n    = nr + 1;
        k    = nc + 1;
        dn   = (clr != 0) ? n + 3 : n + 2;
        last = dn + 2;
        mask = COLS'((32'd1 << k) - 1);
        @(negedge clk);
        submat_row_in = SMR'(sr);
        submat_col_in = SMC'(sc);
        num_rows_read = RW'(nr);
        num_cols_read = CW'(nc);
        activate      = 1'(act);
        clear_after   = 1'(clr);
        wr_base_addr  = AW'(base);
        start         = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            scramble();
            start   = (cyc == restart_cyc) || (restart_done && cyc == dn);
            reset   = !(cyc == rst_cyc);
            aborted = (rst_cyc > 0) && (cyc > rst_cyc);
            @(negedge clk);
            if (aborted) begin
                chk("abort_wr_en", 256'(wr_en), 256'(0));
                chk("abort_wr_addr", 256'(wr_addr), 256'(0));
                chk("abort_ctrl", 256'({done, accum_reset, relu_en, row_num, submat_row_out, submat_col_out}), 256'(0));
            end else begin
                chk("submat", 256'({submat_row_out, submat_col_out}), 256'({SMR'(sr), SMC'(sc)}));
                chk("wr_en", 256'(wr_en), (cyc >= 2 && cyc <= n + 1) ? 256'(mask) : 256'(0));
                if (cyc == 1)          a = prev_addr;
                else if (cyc <= n + 1) a = AW'(base + cyc - 2);
                else                   a = AW'(base + n - 1);
                chk("wr_addr", 256'(wr_addr), 256'({COLS{a}}));
                chk("accum_reset", 256'(accum_reset), 256'((clr != 0) && cyc == n + 2));
                chk("done", 256'(done), 256'(cyc == dn));
                if (cyc <= n)       chk("row_num", 256'(row_num), 256'(cyc - 1));
                else if (cyc > dn)  chk("row_num_idle", 256'(row_num), 256'(0));
                if (cyc <= n + 1 + ((clr != 0) ? 1 : 0)) chk("relu_en", 256'(relu_en), 256'(act != 0));
                else if (cyc > dn)  chk("relu_en_idle", 256'(relu_en), 256'(0));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b1;
        if (rst_cyc > 0) prev_addr = '0;
        else             prev_addr = AW'(base + n - 1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wr", 256'({wr_en, wr_addr}), 256'(0));
        chk("reset_ctrl", 256'({done, accum_reset, relu_en, row_num, submat_row_out, submat_col_out}), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        xfer(2, 3, 15, 9, 1, 1, 2, 0, 0, 1'b0);
        xfer(2, 3, 15, 9, 0, 0, 2, 0, 0, 1'b0);
        xfer(1, 4, 0, 15, 1, 0, 255, 0, 0, 1'b0);
        xfer(5, 6, 15, 15, 1, 1, 250, 0, 0, 1'b0);
        xfer(7, 1, 15, 3, 1, 1, 40, 0, 3, 1'b1);
        xfer(3, 2, 7, 2, 0, 0, 17, 0, 5, 1'b1);
        xfer(4, 5, 15, 9, 1, 1, 100, 5, 0, 1'b0);
        xfer(2, 2, 15, 9, 1, 0, 60, 0, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            xfer(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 6)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
